// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo-path blocks.
//   BYTE_W          : width of one UART character
//   byte_t          : one UART character
//   tx_buf_state_e  : states of the transmit-side drain FSM in uart_tx_buffer
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_buf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a sticky overflow flag.
// Ports:
//   clk50, reset   : clock and asynchronous active-high reset
//   push, din      : write request and data; a push while full is dropped
//                    unless a pop happens in the same cycle
//   pop            : read request; ignored while empty
//   clr_overflow   : synchronous clear of overflow (a new drop wins)
//   dout           : combinational view of the oldest entry
//   level          : occupancy 0..DEPTH
//   empty, full    : level == 0, level == DEPTH
//   overflow       : sticky, set when a pushed word was dropped
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_overflow,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk50) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear so a drop is never hidden by a clear.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer between the UART receiver and transmitter of the echo path.
// Every receiver strobe pushes one byte; bytes are drained to the
// transmitter one frame at a time with a single-cycle start pulse.
// Ports:
//   clk50, reset       : 50 MHz clock, asynchronous active-high reset
//   rx_valid, rx_data  : receiver strobe (any length) and its byte
//   tx_busy            : transmitter busy flag
//   clr_overflow       : synchronous clear of overflow
//   tx_start, tx_data  : start pulse and byte for the transmitter
//   level, empty, full : FIFO occupancy status
//   overflow           : sticky flag, a byte was dropped while full
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BUSY_WAIT = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              tx_busy,
  input  logic              clr_overflow,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_WAIT - 1);

  tx_buf_state_e state;
  tx_buf_state_e next_state;
  logic          rx_valid_d;
  logic          push;
  logic          pop;
  byte_t         fifo_dout;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;

  // Only the rising edge of the strobe counts, so a long strobe is one byte.
  assign push = rx_valid & ~rx_valid_d;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rx_valid_d <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk50        (clk50),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .clr_overflow (clr_overflow),
    .din          (rx_data),
    .dout         (fifo_dout),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  // Drain FSM. A transmitter that never raises busy would stall the echo
  // path forever, so WAIT_BUSY gives up after BUSY_WAIT cycles and treats
  // the byte as sent.
  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (~empty & ~tx_busy) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        wait_cnt_next = '0;
        next_state    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (~tx_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // tx_start is a flop that is high exactly while the FSM sits in START;
  // tx_data is only reloaded in the pop cycle so it is stable for a frame.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      tx_start <= (next_state == START);
      if (pop) begin
        tx_data <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int BUSY_WAIT = 4;
  localparam int AW = $clog2(DEPTH);

  logic          clk50 = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_busy;
  logic          clr_overflow = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          overflow;

  logic          model_busy = 1'b0;
  logic          force_busy = 1'b0;
  bit            tx_model_en = 1'b1;
  int            busy_len = 80;

  int            cyc = 0;
  int            n_compared = 0;
  int            n_mismatched = 0;

  logic [7:0]    sent[$];
  int            start_cycles[$];

  // Reference model state
  logic [7:0]    mq[$];
  bit            m_prev_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_start = 1'b0;
  bit            m_in_flight = 1'b0;
  bit            m_busy_seen = 1'b0;
  logic [7:0]    m_data = 8'h00;
  int            m_pop_cyc = 0;

  assign tx_busy = model_busy | force_busy;

  uart_tx_buffer #(
    .DEPTH     (DEPTH),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk50        (clk50),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_busy      (tx_busy),
    .clr_overflow (clr_overflow),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  // 50 MHz clock
  always #10 clk50 = ~clk50;

  // Cycle counter, used to time start pulses
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One receiver strobe of len cycles, followed by one low cycle.
  // Called and returns #1 after a rising clock edge.
  task automatic applyStimulus(input logic [7:0] d, input int len);
    rx_data  = d;
    rx_valid = 1'b1;
    repeat (len) begin
      @(posedge clk50);
      #1;
    end
    rx_valid = 1'b0;
    @(posedge clk50);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  // Transmitter stand-in: after each start pulse it is busy for busy_len cycles
  initial begin
    forever begin
      @(negedge clk50);
      if (tx_start && tx_model_en) begin
        @(posedge clk50);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clk50);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Log every start pulse with its byte and cycle
  always @(negedge clk50) begin
    if (tx_start) begin
      sent.push_back(tx_data);
      start_cycles.push_back(cyc);
    end
  end

  // Reference model: a byte queue plus the rule that the transmitter side
  // is occupied from a pop until either busy has been seen and dropped
  // again, or BUSY_WAIT cycles after the start cycle pass with no busy.
  initial begin
    bit do_pop;
    bit do_push;
    forever begin
      @(posedge clk50 or posedge reset);
      if (reset) begin
        mq.delete();
        m_prev_valid = 1'b0;
        m_ovf        = 1'b0;
        m_start      = 1'b0;
        m_in_flight  = 1'b0;
        m_busy_seen  = 1'b0;
        m_data       = 8'h00;
      end else begin
        do_pop  = !m_in_flight && (mq.size() > 0) && !tx_busy;
        do_push = rx_valid && !m_prev_valid;
        m_prev_valid = rx_valid;
        if (m_in_flight && cyc >= m_pop_cyc + 2) begin
          if (!m_busy_seen) begin
            if (tx_busy) m_busy_seen = 1'b1;
            else if (cyc - m_pop_cyc - 1 == BUSY_WAIT) m_in_flight = 1'b0;
          end else if (!tx_busy) begin
            m_in_flight = 1'b0;
          end
        end
        if (do_pop) begin
          m_data      = mq.pop_front();
          m_in_flight = 1'b1;
          m_busy_seen = 1'b0;
          m_pop_cyc   = cyc;
        end
        if (clr_overflow) m_ovf = 1'b0;
        if (do_push) begin
          if (mq.size() < DEPTH) mq.push_back(rx_data);
          else m_ovf = 1'b1;
        end
        m_start = do_pop;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk50);
      checkOutput("tx_start", 32'(tx_start), 32'(m_start));
      checkOutput("tx_data", 32'(tx_data), 32'(m_data));
      checkOutput("level", 32'(level), 32'(mq.size()));
      checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Directed scenarios
  initial begin
    int rise_cyc;

    // Reset
    waitCycles(3);
    checkOutput("rst_tx_start", 32'(tx_start), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_empty", 32'(empty), 32'h1);
    checkOutput("rst_full", 32'(full), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    waitCycles(2);

    // Single byte: pulse lands in the third cycle counted from the strobe
    sent.delete();
    start_cycles.delete();
    rise_cyc = cyc;
    applyStimulus(8'hA5, 1);
    @(negedge clk50);
    checkOutput("single_start", 32'(tx_start), 32'h1);
    checkOutput("single_data", 32'(tx_data), 32'hA5);
    checkOutput("single_level", 32'(level), 32'h0);
    waitCycles(100);
    checkOutput("single_count", 32'(sent.size()), 32'd1);
    if (start_cycles.size() > 0)
      checkOutput("single_latency", 32'(start_cycles[0] - rise_cyc), 32'd2);

    // Burst of five bytes, one every 10 cycles, 80-cycle frames
    sent.delete();
    start_cycles.delete();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1);
      waitCycles(8);
    end
    waitCycles(450);
    checkOutput("burst_count", 32'(sent.size()), 32'd5);
    for (int i = 0; i < 5 && i < sent.size(); i++)
      checkOutput("burst_data", 32'(sent[i]), 32'(i + 1));
    for (int i = 0; i < 4 && i + 1 < start_cycles.size(); i++)
      checkOutput("burst_spacing", 32'(start_cycles[i+1] - start_cycles[i]), 32'd83);
    checkOutput("burst_overflow", 32'(overflow), 32'h0);

    // Overflow: transmitter held busy, DEPTH+2 bytes pushed
    force_busy = 1'b1;
    sent.delete();
    start_cycles.delete();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(8'(8'h10 + i), 1);
    @(negedge clk50);
    checkOutput("ovf_full", 32'(full), 32'h1);
    checkOutput("ovf_level", 32'(level), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'h1);
    waitCycles(1);
    force_busy = 1'b0;
    waitCycles(1400);
    checkOutput("ovf_count", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      checkOutput("ovf_data", 32'(sent[i]), 32'(8'h10 + i));
    clr_overflow = 1'b1;
    waitCycles(1);
    clr_overflow = 1'b0;
    @(negedge clk50);
    checkOutput("ovf_cleared", 32'(overflow), 32'h0);
    waitCycles(1);

    // Long strobe: five-cycle rx_valid is one byte
    sent.delete();
    start_cycles.delete();
    applyStimulus(8'h3C, 5);
    waitCycles(100);
    checkOutput("long_count", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) checkOutput("long_data", 32'(sent[0]), 32'h3C);

    // Busy timeout: transmitter never raises busy
    tx_model_en = 1'b0;
    sent.delete();
    start_cycles.delete();
    applyStimulus(8'h7E, 1);
    applyStimulus(8'h7F, 1);
    waitCycles(20);
    checkOutput("tmo_count", 32'(sent.size()), 32'd2);
    if (sent.size() == 2) begin
      checkOutput("tmo_data0", 32'(sent[0]), 32'h7E);
      checkOutput("tmo_data1", 32'(sent[1]), 32'h7F);
      checkOutput("tmo_spacing", 32'(start_cycles[1] - start_cycles[0]), 32'(BUSY_WAIT + 2));
    end

    // Reset in the middle of a frame with two bytes still queued
    tx_model_en = 1'b1;
    applyStimulus(8'hC1, 1);
    applyStimulus(8'hC2, 1);
    applyStimulus(8'hC3, 1);
    waitCycles(4);
    checkOutput("mid_level", 32'(level), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_start", 32'(tx_start), 32'h0);
    checkOutput("mid_rst_level", 32'(level), 32'h0);
    checkOutput("mid_rst_empty", 32'(empty), 32'h1);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'h0);
    waitCycles(2);
    reset = 1'b0;
    sent.delete();
    start_cycles.delete();
    waitCycles(200);
    checkOutput("post_rst_starts", 32'(sent.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte buffer between the UART receiver and transmitter in the echo path.
- Captures every byte strobed by the receiver into a FIFO, so bytes that arrive while the transmitter is busy are not dropped.
- Drains the FIFO into the transmitter, issuing one single-cycle start pulse per byte.
- Replaces direct rx→tx start-pulse generation in the echo top level.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, minimum 2.
- BUSY_WAIT, 4, max cycles after a start pulse to wait for tx_busy to rise before the byte is treated as sent.
- AW (localparam), $clog2(DEPTH), pointer width.

Ports:
- clk50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  receiver data-valid; may be a level longer than one cycle
- rx_data  in  8  receiver byte, stable while rx_valid is high
- tx_busy  in  1  transmitter busy flag
- clr_overflow  in  1  synchronous clear of the overflow flag
- tx_start  out  1  single-cycle start pulse to the transmitter
- tx_data  out  8  byte presented to the transmitter
- level  out  AW+1  current FIFO occupancy, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async, reset high):
  - Pointers = 0, level = 0, empty = 1, full = 0, overflow = 0.
  - tx_start = 0, tx_data = 8'h00, FSM = IDLE, rx_valid_d = 0.
  - Storage contents are not reset.
- Push:
  - push = rx_valid & ~rx_valid_d (rising edge); exactly one push per strobe regardless of strobe length.
  - rx_data is written at the write pointer on the push cycle.
  - The write pointer wraps modulo DEPTH.
- Pop: occurs only in the IDLE→START transition cycle (see FSM); the read pointer wraps modulo DEPTH.
- Level update: level += push_accepted − pop.
- Full boundary:
  - Push while full with no pop in the same cycle: byte dropped, overflow ← 1, level unchanged.
  - Push and pop in the same cycle while full: push accepted, level stays DEPTH.
- Empty boundary: push and pop in the same cycle while empty is impossible, because pop requires ~empty; the pushed byte is popped no earlier than the next cycle.
- Overflow flag: clr_overflow clears it. If a clear and a new overflow event occur in the same cycle, set wins.
- FSM states:
  - IDLE:
    - If ~empty & ~tx_busy: tx_data ← mem[rd_ptr], pop, next = START.
  - START:
    - tx_start = 1 for exactly this one cycle.
    - tx_data is held; next = WAIT_BUSY with the timeout counter cleared.
  - WAIT_BUSY:
    - If tx_busy: next = WAIT_DONE.
    - Else the counter increments; when it reaches BUSY_WAIT−1 without tx_busy, next = IDLE (byte considered sent).
  - WAIT_DONE:
    - Wait until ~tx_busy, then next = IDLE.
- Timing: tx_start is registered. Latency from the rx_valid rising edge (FIFO empty, tx idle) to tx_start high is 3 clk50 cycles: edge detect/push, IDLE pop, START.
- tx_data is stable from START through the return to IDLE. It changes only in the IDLE pop cycle.
- Back-to-back bytes: the next pop waits for IDLE plus ~tx_busy, so there is at most one start pulse per transmitter frame.
- tx_start is never asserted while tx_busy is high at the START cycle entry decision (IDLE checks ~tx_busy).
- Reset mid-frame: all state clears immediately; buffered bytes are lost; tx_start is deasserted asynchronously.

Decomposition:
- Package uart_pkg: BYTE_W = 8, typedef byte_t (logic [7:0]), and the FSM state enum tx_buf_state_e {IDLE, START, WAIT_BUSY, WAIT_DONE}.
- Sub-module sync_fifo (parameters DEPTH, WIDTH):
  - Ports: push, pop, din, dout, level, empty, full.
  - Behaviour: dout is combinational from mem[rd_ptr]; overflow detection is done there.
- uart_tx_buffer instantiates sync_fifo and contains the edge detector and the FSM.

Test Plan:
- Single byte: rx_valid pulse with rx_data = 8'hA5, tx idle → tx_start high 3 cycles after the rising edge, tx_data = 8'hA5; level goes 0→1→0.
- Burst: push 8'h01..8'h05, one per 10 cycles; tx model busy for 80 cycles after each start → five start pulses, data in order 01..05, each pulse following a tx_busy falling edge; overflow stays 0.
- Overflow: hold tx_busy = 1, push DEPTH+2 bytes 8'h10.. → full = 1, level = 16, overflow = 1. After tx_busy is released, exactly 8'h10..8'h1F are sent; 8'h20 and 8'h21 are lost. clr_overflow pulse → overflow = 0.
- Long strobe: rx_valid held high for 5 cycles with 8'h3C → exactly one push, one tx_start.
- Busy timeout: tx model never asserts busy; push 8'h7E, 8'h7F → two start pulses spaced by BUSY_WAIT+2 cycles, FSM returns to IDLE each time.
- Reset mid-operation: 3 bytes buffered, first in WAIT_DONE; assert reset for 2 cycles → tx_start = 0, level = 0, empty = 1, overflow = 0 immediately. After release, no start pulse without new rx_valid.
